ins_fetch: RTL
==============

Name: ins_fetch

Overview:
- Instruction fetch sequencer for the 4-bit-opcode teaching CPU.
- Reads instruction bytes from program memory over a req/ack handshake and holds the program counter.
- Presents opcode ir[3:0] plus a one-cycle en strobe to the instruction decoder directly downstream.
- Waits for the datapath to finish execution, then applies jmp/jg redirects and stops on halt.

Parameters:
- AW, 8: program-counter / memory address width.
- DW, 8: memory data width; bits [7:4] are the opcode, bits [3:0] the register field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; start fetching from IDLE.
- mem_rd  out  1  read request, held until mem_ack.
- mem_addr  out  AW  read address, stable while mem_rd=1.
- mem_ack  in  1  one-cycle read completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DW  read data.
- ir  out  4  registered opcode to the decoder.
- fld  out  4  registered low nibble of the instruction byte (register selects).
- imm  out  DW  registered second byte (immediate or jump target).
- en  out  1  decoder enable, exactly one cycle per instruction.
- exec_done  in  1  datapath finished the current instruction.
- br_taken  in  1  jg condition, sampled with exec_done.
- pc  out  AW  current program counter.
- halted  out  1  high in HALTED.
- illegal  out  1  sticky; set when opcode 0000-0011 is fetched.

Behaviour:
- Reset (async, immediate): state=IDLE. pc, ir, fld, imm, en, mem_rd, halted and illegal all 0. mem_addr follows pc, so it reads 0.
- Reset during a memory request drops mem_rd at once; a later stray mem_ack is ignored.
- Two-byte opcodes are 1010 (jmp), 1011 (jg) and 1110 (movi). All other opcodes are one byte.
- IDLE: run=1 -> FETCH1 on the next edge.
- FETCH1: mem_rd=1, mem_addr=pc. On mem_ack:
  - {ir,fld} <= mem_rdata and pc <= pc+1.
  - Two-byte opcode -> FETCH2.
  - Opcode 0000-0011 -> set illegal and go to FETCH1 (skipped; no en issued).
  - Otherwise -> DECODE.
- FETCH2: mem_rd=1, mem_addr=pc. On mem_ack: imm <= mem_rdata, pc <= pc+1, -> DECODE.
- DECODE: en=1 for exactly this cycle. ir, fld and imm are stable.
  - ir=1111 -> HALTED.
  - Otherwise -> EXEC.
- EXEC: waits for exec_done; en=0 and mem_rd=0. On exec_done:
  - pc <= imm if ir=1010, or if ir=1011 and br_taken=1; pc is otherwise unchanged.
  - Next state FETCH1.
- HALTED: halted=1; all strobes low. The only exit is rst.
- Minimum latency:
  - One-byte instruction with zero-wait memory (ack in the first request cycle): FETCH1 -> DECODE -> EXEC = 3 cycles.
  - Two-byte instruction: 4 cycles, plus exec_done wait.
- pc wraps modulo 2^AW: 8'hFF+1 = 8'h00. An imm fetch across the wrap uses address 0.
- mem_ack outside FETCH1/FETCH2 is ignored. exec_done and br_taken outside EXEC are ignored.
- run is only sampled in IDLE; deasserting run mid-program has no effect.
- en never asserts in two consecutive cycles.

Optional Feature:
- Macro: INS_FETCH_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After EXEC completes, the block enters state PAUSE instead of FETCH1.
  - PAUSE -> FETCH1 on the first cycle step=1. A step held high advances only one instruction: the pulse is edge-detected internally, with the edge register reset to 0.
  - A jump is applied on exec_done, before PAUSE.
- Undefined: no step port and no PAUSE state; EXEC goes directly to FETCH1.

Decomposition:
- Shared header ins_defs.vh holds:
  - Opcode constants OP_MOVA..OP_HALT (0100..1111).
  - State encodings ST_IDLE, ST_FETCH1, ST_FETCH2, ST_DECODE, ST_EXEC, ST_HALTED, ST_PAUSE.
  - The two-byte-opcode predicate macro.
- The decoder includes the same header.
- One sub-module is natural: pc_reg.
  - Parameter AW; inputs inc and load with load data; async rst to 0.
  - load has priority over inc.

Test Plan:
- Program at 0x00: 0x41 (mova), 0xF0 (halt); ack every cycle; run=1, exec_done is a one-cycle pulse 2 cycles into each EXEC -> en pulses with ir=0100 then ir=1111; halted=1; pc=0x02; no further mem_rd.
- 0xA0,0x10 (jmp 0x10) at 0x00, 0xF0 at 0x10 -> imm=0x10; after exec_done pc=0x10; the next fetch uses mem_addr=0x10; halts.
- jg (0xB0,0x20) at 0x00, run once with br_taken=0 and once with br_taken=1 -> not-taken gives pc=0x02; taken gives pc=0x20.
- Memory holds 0x25 then 0x41 with ack delayed 3 cycles per request -> mem_addr stays stable while mem_rd=1; illegal=1; no en for 0x25; en fires with ir=0100.
- pc starts at 0xFF via jmp 0xFF; 0xE0 at 0xFF and 0x7A at 0x00 -> imm=0x7A; pc wraps to 0x01.
- rst asserted mid-FETCH2 with mem_rd=1, then mem_ack pulsed the following cycle -> mem_rd drops at once; pc=0; state IDLE; late ack ignored. With INS_FETCH_STEP_EN, step held high advances exactly one instruction.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// Shared opcode constants, FSM state encoding and opcode predicates for the
// ins_fetch instruction sequencer and the decoder downstream of it.
package ins_fetch_pkg;

    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_JG   = 4'b1011;
    localparam logic [3:0] OP_MOVI = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH1,
        ST_FETCH2,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED,
        ST_PAUSE
    } state_t;

    // Opcodes that carry an immediate / jump-target byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return op inside {OP_JMP, OP_JG, OP_MOVI};
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/ins_fetch_pc_reg.sv
// Program counter register: async reset to 0, load takes priority over increment,
// increment wraps modulo 2^AW.
module pc_reg #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (inc)
            q <= q + AW'(1);
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch sequencer: fetches 1/2-byte instructions over req/ack, strobes
// the decoder, applies jmp/jg on exec_done. Define INS_FETCH_STEP_EN for single-step.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
`ifdef INS_FETCH_STEP_EN
    input  logic          step,
`endif
    input  logic          run,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [3:0]    ir,
    output logic [3:0]    fld,
    output logic [DW-1:0] imm,
    output logic          en,
    input  logic          exec_done,
    input  logic          br_taken,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          illegal
);

    state_t state, state_nxt;
    logic   ack_f1, ack_f2, do_jump, step_go;

    assign ack_f1  = (state == ST_FETCH1) && mem_ack;
    assign ack_f2  = (state == ST_FETCH2) && mem_ack;
    assign do_jump = (state == ST_EXEC) && exec_done &&
                     ((ir == OP_JMP) || ((ir == OP_JG) && br_taken));

`ifdef INS_FETCH_STEP_EN
    // Edge-detect step so a held level releases only one instruction.
    logic step_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_q <= 1'b0;
        else
            step_q <= step;
    end
    assign step_go = step && !step_q;
`else
    assign step_go = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (run) state_nxt = ST_FETCH1;
            ST_FETCH1: if (mem_ack) begin
                if (is_two_byte(mem_rdata[7:4]))
                    state_nxt = ST_FETCH2;
                else if (is_illegal(mem_rdata[7:4]))
                    state_nxt = ST_FETCH1;
                else
                    state_nxt = ST_DECODE;
            end
            ST_FETCH2: if (mem_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (ir == OP_HALT) ? ST_HALTED : ST_EXEC;
`ifdef INS_FETCH_STEP_EN
            ST_EXEC:   if (exec_done) state_nxt = ST_PAUSE;
            ST_PAUSE:  if (step_go) state_nxt = ST_FETCH1;
`else
            ST_EXEC:   if (exec_done) state_nxt = ST_FETCH1;
`endif
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd = (state == ST_FETCH1) || (state == ST_FETCH2);
        en     = (state == ST_DECODE);
        halted = (state == ST_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= '0;
            fld     <= '0;
            imm     <= '0;
            illegal <= 1'b0;
        end else begin
            if (ack_f1) begin
                ir  <= mem_rdata[7:4];
                fld <= mem_rdata[3:0];
                if (is_illegal(mem_rdata[7:4]))
                    illegal <= 1'b1;
            end
            if (ack_f2)
                imm <= mem_rdata;
        end
    end

    pc_reg #(.AW(AW)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .inc  (ack_f1 || ack_f2),
        .load (do_jump),
        .d    (imm[AW-1:0]),
        .q    (pc)
    );

    assign mem_addr = pc;

    logic unused_step;
    assign unused_step = step_go;

endmodule
